// File: rtl/fc_param_store.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fc_param_store
// Brief    : Loads FC weights and per-channel quant records from parameter
//            memory through a handshaked read port, then serves zero-latency
//            weight/record lookups to the FC engine.
// Revision : 1.0 - initial release
// ============================================================================
module fc_param_store #(
  parameter int DATA_W     = 8,
  parameter int MUL_W      = 32,
  parameter int ACC_W      = 32,
  parameter int SHIFT_W    = 6,
  parameter int ADDR_W     = 32,
  parameter int DIM_W      = 16,
  parameter int MEM_W      = 32,
  parameter int MAX_IN_CH  = 1024,
  parameter int MAX_OUT_CH = 16,
  parameter int MAX_OUTST  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load_start,
  input  logic [DIM_W-1:0]           cfg_in_c,
  input  logic [DIM_W-1:0]           cfg_out_c,
  input  logic [ADDR_W-1:0]          cfg_param_base,
  output logic                       load_busy,
  output logic                       load_done,
  output logic                       load_err,
  output logic                       params_valid,
  output logic                       mem_rd_req,
  output logic [ADDR_W-1:0]          mem_rd_addr,
  input  logic                       mem_rd_gnt,
  input  logic                       mem_rd_valid,
  input  logic [MEM_W-1:0]           mem_rd_data,
  input  logic [DIM_W-1:0]           fc_in_idx,
  input  logic [DIM_W-1:0]           fc_out_idx,
  output logic signed [DATA_W-1:0]   fc_weight,
  output logic signed [ACC_W-1:0]    fc_bias_acc,
  output logic signed [MUL_W-1:0]    fc_mul,
  output logic [SHIFT_W-1:0]         fc_shift,
  output logic signed [DATA_W-1:0]   fc_zp
);

  // Weight storage is addressed as {row, col}; this equals row*MAX_IN_CH+col
  // because MAX_IN_CH is a power of two.
  localparam int IN_AW  = (MAX_IN_CH  > 1) ? $clog2(MAX_IN_CH)  : 1;
  localparam int OUT_AW = (MAX_OUT_CH > 1) ? $clog2(MAX_OUT_CH) : 1;
  localparam int OST_W  = $clog2(MAX_OUTST + 1);
  localparam int CNT_W  = 32;

  localparam logic [DIM_W-1:0] c_max_in  = DIM_W'(MAX_IN_CH);
  localparam logic [DIM_W-1:0] c_max_out = DIM_W'(MAX_OUT_CH);
  localparam logic [OST_W-1:0] c_max_ost = OST_W'(MAX_OUTST);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_READY = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DIM_W-1:0]    r_in_c;
  logic [DIM_W-1:0]    r_out_c;
  logic [ADDR_W-1:0]   r_base;
  logic [CNT_W-1:0]    r_n;
  logic [CNT_W-1:0]    r_wtot;
  logic [CNT_W-1:0]    r_issue_cnt;
  logic [CNT_W-1:0]    r_recv_cnt;
  logic [OST_W-1:0]    r_outst;
  logic [OUT_AW-1:0]   r_wrow;
  logic [IN_AW-1:0]    r_wcol;
  logic [OUT_AW-1:0]   r_rch;
  logic [1:0]          r_rfld;
  logic                r_done;
  logic                r_err;
  logic                r_pvalid;

  logic [DATA_W-1:0]   r_wmem  [MAX_OUT_CH*MAX_IN_CH];
  logic [ACC_W-1:0]    r_bias  [MAX_OUT_CH];
  logic [MUL_W-1:0]    r_mul   [MAX_OUT_CH];
  logic [SHIFT_W-1:0]  r_shift [MAX_OUT_CH];
  logic [DATA_W-1:0]   r_zp    [MAX_OUT_CH];

  logic                w_req;
  logic                w_grant;
  logic                w_resp;
  logic                w_cfg_bad;
  logic                w_can_start;
  logic                w_start_ok;
  logic                w_start_bad;
  logic                w_issue_last;
  logic                w_recv_last;
  logic                w_is_weight;
  logic                w_col_last;
  logic [CNT_W-1:0]    w_wtot_cfg;
  logic [CNT_W-1:0]    w_n_cfg;
  logic                w_hit;
  logic [OUT_AW+IN_AW-1:0] w_widx;
  logic [OUT_AW-1:0]   w_ridx;

  assign w_cfg_bad   = (cfg_in_c == '0) || (cfg_out_c == '0) ||
                       (cfg_in_c > c_max_in) || (cfg_out_c > c_max_out);
  assign w_can_start = (r_state == S_IDLE) || (r_state == S_READY);
  assign w_start_ok  = load_start && w_can_start && !w_cfg_bad;
  assign w_start_bad = load_start && w_can_start && w_cfg_bad;
  assign w_wtot_cfg  = CNT_W'(cfg_out_c) * CNT_W'(cfg_in_c);
  assign w_n_cfg     = CNT_W'(cfg_out_c) * (CNT_W'(cfg_in_c) + CNT_W'(4));

  // A response is only accepted while reads are outstanding, so stray data
  // after a reset or before any request is dropped.
  assign w_grant      = w_req && mem_rd_gnt;
  assign w_resp       = mem_rd_valid && (r_outst != '0);
  assign w_issue_last = (r_issue_cnt == r_n - CNT_W'(1));
  assign w_recv_last  = (r_recv_cnt == r_n - CNT_W'(1));
  assign w_is_weight  = (r_recv_cnt < r_wtot);
  assign w_col_last   = (DIM_W'(r_wcol) == r_in_c - DIM_W'(1));

  // Next-state and read-request decode.
  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    case (r_state)
      S_IDLE, S_READY: begin
        if (w_start_ok) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        w_req = (r_outst < c_max_ost);
        if (w_req && mem_rd_gnt && w_issue_last) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_resp && w_recv_last) w_state_nxt = S_READY;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, configuration, counters and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_c      <= '0;
      r_out_c     <= '0;
      r_base      <= '0;
      r_n         <= '0;
      r_wtot      <= '0;
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
      r_outst     <= '0;
      r_wrow      <= '0;
      r_wcol      <= '0;
      r_rch       <= '0;
      r_rfld      <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_pvalid    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_start_bad;
      r_done  <= 1'b0;
      if ((r_state == S_DRAIN) && (w_state_nxt == S_READY)) begin
        r_done   <= 1'b1;
        r_pvalid <= 1'b1;
      end

      // A grant and a response in the same cycle cancel out.
      if (w_grant && !w_resp)      r_outst <= r_outst + OST_W'(1);
      else if (!w_grant && w_resp) r_outst <= r_outst - OST_W'(1);

      if (w_start_ok) begin
        r_in_c      <= cfg_in_c;
        r_out_c     <= cfg_out_c;
        r_base      <= cfg_param_base;
        r_n         <= w_n_cfg;
        r_wtot      <= w_wtot_cfg;
        r_issue_cnt <= '0;
        r_recv_cnt  <= '0;
        r_wrow      <= '0;
        r_wcol      <= '0;
        r_rch       <= '0;
        r_rfld      <= '0;
        r_pvalid    <= 1'b0;
      end else begin
        if (w_grant) r_issue_cnt <= r_issue_cnt + CNT_W'(1);
        if (w_resp) begin
          r_recv_cnt <= r_recv_cnt + CNT_W'(1);
          if (w_is_weight) begin
            if (w_col_last) begin
              r_wcol <= '0;
              r_wrow <= r_wrow + OUT_AW'(1);
            end else begin
              r_wcol <= r_wcol + IN_AW'(1);
            end
          end else begin
            r_rfld <= r_rfld + 2'd1;
            if (r_rfld == 2'd3) r_rch <= r_rch + OUT_AW'(1);
          end
        end
      end
    end
  end

  // Parameter storage writes, steered by the receive counters.
  always_ff @(posedge clk) begin
    if (w_resp) begin
      if (w_is_weight) begin
        r_wmem[{r_wrow, r_wcol}] <= mem_rd_data[DATA_W-1:0];
      end else begin
        case (r_rfld)
          2'd0:    r_bias[r_rch]  <= mem_rd_data[ACC_W-1:0];
          2'd1:    r_mul[r_rch]   <= mem_rd_data[MUL_W-1:0];
          2'd2:    r_shift[r_rch] <= mem_rd_data[SHIFT_W-1:0];
          default: r_zp[r_rch]    <= mem_rd_data[DATA_W-1:0];
        endcase
      end
    end
  end

  assign load_busy    = (r_state == S_ISSUE) || (r_state == S_DRAIN);
  assign load_done    = r_done;
  assign load_err     = r_err;
  assign params_valid = r_pvalid;
  assign mem_rd_req   = w_req;
  assign mem_rd_addr  = (r_state == S_ISSUE) ? (r_base + ADDR_W'(r_issue_cnt)) : '0;

  // Lookup path: purely combinational, zero when either index is out of range.
  assign w_hit  = (fc_in_idx < r_in_c) && (fc_out_idx < r_out_c);
  assign w_widx = {fc_out_idx[OUT_AW-1:0], fc_in_idx[IN_AW-1:0]};
  assign w_ridx = fc_out_idx[OUT_AW-1:0];

  assign fc_weight   = w_hit ? r_wmem[w_widx]  : '0;
  assign fc_bias_acc = w_hit ? r_bias[w_ridx]  : '0;
  assign fc_mul      = w_hit ? r_mul[w_ridx]   : '0;
  assign fc_shift    = w_hit ? r_shift[w_ridx] : '0;
  assign fc_zp       = w_hit ? r_zp[w_ridx]    : '0;

endmodule
`default_nettype wire
